// File: rtl/fb_port_arbiter.sv
// Generic first-word-fall-through FIFO used for the camera write queue.
// Latency: an entry pushed at edge E is visible on rd_dat after E.
// Backpressure: wr_rdy drops only when full and no pop is taken in the same cycle.
module fb_fifo #(
    parameter int  W     = 32,
    parameter int  DEPTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_vld,
    input  logic [W-1:0]     wr_dat,
    output logic             wr_rdy,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [W-1:0]     rd_dat,
    output logic [LVL_W-1:0] level
);
    logic [W-1:0]     store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign rd_vld = (level != '0);
    assign pop    = rd_vld && rd_rdy;
    assign wr_rdy = (level != LVL_W'(DEPTH)) || pop;
    assign push   = wr_vld && wr_rdy;
    assign rd_dat = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// Double-buffered frame-buffer arbiter: display reads win, camera writes drain from a FIFO.
// Latency: read issue 1 cycle after disp_rd, data/valid 2 cycles after; queued write issued 1 cycle after push.
// Backpressure: none upstream; camera pushes to a full FIFO are dropped and flagged in fifo_overflow.
module fb_port_arbiter #(
    parameter int  ADDR_W     = 19,
    parameter int  DATA_W     = 12,
    parameter int  FIFO_DEPTH = 64,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              disp_frame_start,
    input  logic              disp_rd,
    input  logic [ADDR_W-1:0] disp_rd_addr,
    output logic [DATA_W-1:0] disp_rd_data,
    output logic              disp_rd_valid,
    output logic              disp_bank,
    input  logic              cam_wr,
    input  logic              cam_eof,
    input  logic [ADDR_W-1:0] cam_wr_addr,
    input  logic [DATA_W-1:0] cam_wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              fifo_overflow,
    input  logic              ovf_clr,
    output logic [7:0]        frames_dropped
);
    typedef struct packed {
        logic              eof;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cam_ent_t;

    cam_ent_t wr_ent;
    cam_ent_t head;
    logic     fifo_wr_rdy;
    logic     fifo_vld;
    logic     pop_req;
    logic     do_pop;
    logic     wr_bank;
    logic     frame_ready;
    logic     first_px;
    logic     drop_hit;

    assign wr_ent  = {cam_eof, cam_wr_addr, cam_wr_data};
    // Frame-start cycles never pop, so no write can land in a bank mid-swap.
    assign pop_req = !disp_rd && !disp_frame_start;
    assign do_pop  = pop_req && fifo_vld;

    fb_fifo #(
        .W     ($bits(cam_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cam_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .wr_vld (cam_wr),
        .wr_dat (wr_ent),
        .wr_rdy (fifo_wr_rdy),
        .rd_rdy (pop_req),
        .rd_vld (fifo_vld),
        .rd_dat (head),
        .level  (fifo_level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            disp_rd_valid <= 1'b0;
        end else begin
            mem_en        <= disp_rd || do_pop;
            mem_we        <= do_pop;
            disp_rd_valid <= mem_en && !mem_we;
            if (disp_rd) begin
                mem_addr <= {disp_bank, disp_rd_addr};
            end else if (do_pop) begin
                mem_addr  <= {wr_bank, head.addr};
                mem_wdata <= head.data;
            end
        end
    end

    assign disp_rd_data = disp_rd_valid ? mem_rdata : '0;

    // A completed frame is lost when the next frame's first pixel overwrites its bank.
    assign drop_hit = do_pop && first_px && frame_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_bank      <= 1'b0;
            wr_bank        <= 1'b1;
            frame_ready    <= 1'b0;
            first_px       <= 1'b1;
            frames_dropped <= '0;
        end else begin
            if (disp_frame_start && frame_ready) begin
                disp_bank   <= wr_bank;
                wr_bank     <= disp_bank;
                frame_ready <= 1'b0;
            end else if (do_pop) begin
                first_px <= head.eof;
                if (head.eof) frame_ready <= 1'b1;
                else if (drop_hit) frame_ready <= 1'b0;
            end
            if (drop_hit && frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_overflow <= 1'b0;
        end else if (cam_wr && !fifo_wr_rdy) begin
            fifo_overflow <= 1'b1;
        end else if (ovf_clr) begin
            fifo_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter; the RAM model returns {bank, addr[10:0]} one cycle after a read.
module tb_fb_port_arbiter;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        disp_frame_start = 1'b0;
    logic        disp_rd = 1'b0;
    logic [18:0] disp_rd_addr = '0;
    logic [11:0] disp_rd_data;
    logic        disp_rd_valid;
    logic        disp_bank;
    logic        cam_wr = 1'b0;
    logic        cam_eof = 1'b0;
    logic [18:0] cam_wr_addr = '0;
    logic [11:0] cam_wr_data = '0;
    logic        mem_en;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;
    logic [6:0]  fifo_level;
    logic        fifo_overflow;
    logic        ovf_clr = 1'b0;
    logic [7:0]  frames_dropped;

    int checks = 0;
    int errors = 0;

    fb_port_arbiter dut (
        .clk              (clk),
        .rstn             (rstn),
        .disp_frame_start (disp_frame_start),
        .disp_rd          (disp_rd),
        .disp_rd_addr     (disp_rd_addr),
        .disp_rd_data     (disp_rd_data),
        .disp_rd_valid    (disp_rd_valid),
        .disp_bank        (disp_bank),
        .cam_wr           (cam_wr),
        .cam_eof          (cam_eof),
        .cam_wr_addr      (cam_wr_addr),
        .cam_wr_data      (cam_wr_data),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .fifo_level       (fifo_level),
        .fifo_overflow    (fifo_overflow),
        .ovf_clr          (ovf_clr),
        .frames_dropped   (frames_dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= {mem_addr[19], mem_addr[10:0]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        disp_frame_start = 1'b0;
        disp_rd = 1'b0;
        cam_wr = 1'b0;
        cam_eof = 1'b0;
        ovf_clr = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic push(input logic [18:0] a, input logic [11:0] d, input logic eof);
        cam_wr = 1'b1;
        cam_wr_addr = a;
        cam_wr_data = d;
        cam_eof = eof;
        tick();
        cam_wr = 1'b0;
        cam_eof = 1'b0;
    endtask

    initial begin
        int we_cnt;
        logic [19:0] last_addr;
        logic [11:0] last_dat;
        logic bad_seen;
        logic [19:0] exp_addr [5] = '{20'h80000, 20'h80001, 20'h80002, 20'h0, 20'h0};
        logic [11:0] exp_dat  [5] = '{12'h111, 12'h222, 12'h333, 12'h0, 12'h0};
        logic [11:0] wr_dat   [3] = '{12'h111, 12'h222, 12'h333};

        // Reset state
        do_reset();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_disp_bank", disp_bank, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", fifo_overflow, 0);
        chk("rst_dropped", frames_dropped, 0);
        chk("rst_rd_valid", disp_rd_valid, 0);
        chk("rst_rd_data", disp_rd_data, 0);

        // 1: three back-to-back writes go to bank 1
        for (int i = 0; i < 5; i++) begin
            cam_wr = (i < 3);
            cam_wr_addr = 19'(i);
            cam_wr_data = wr_dat[i % 3];
            tick();
            if (i == 0) begin
                chk("t1_first_push_level", fifo_level, 1);
                chk("t1_first_push_no_we", mem_we, 0);
            end else begin
                chk($sformatf("t1_we_%0d", i), mem_we, (i < 4) ? 1 : 0);
                if (i < 4) begin
                    chk($sformatf("t1_addr_%0d", i), mem_addr, exp_addr[i-1]);
                    chk($sformatf("t1_wdata_%0d", i), mem_wdata, exp_dat[i-1]);
                end
            end
        end
        chk("t1_level_drained", fifo_level, 0);

        // Read path: address into bank 0, data and valid two edges after disp_rd sampled
        disp_rd = 1'b1;
        disp_rd_addr = 19'h123;
        tick();
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 20'h00123);
        chk("rd_valid_early", disp_rd_valid, 0);
        disp_rd = 1'b0;
        tick();
        chk("rd_valid", disp_rd_valid, 1);
        chk("rd_data", disp_rd_data, 12'h123);
        tick();
        chk("rd_valid_fall", disp_rd_valid, 0);
        chk("rd_data_zero", disp_rd_data, 0);

        // 2: long read burst starves writes, then the queue drains
        do_reset();
        we_cnt = 0;
        disp_rd = 1'b1;
        for (int i = 0; i < 640; i++) begin
            cam_wr = (i < 40);
            cam_wr_addr = 19'(i);
            cam_wr_data = 12'(i);
            disp_rd_addr = 19'(i);
            tick();
            if (mem_we) we_cnt++;
        end
        chk("t2_no_we_during_rd", we_cnt, 0);
        chk("t2_level_40", fifo_level, 40);
        cam_wr = 1'b0;
        disp_rd = 1'b0;
        tick();
        chk("t2_drain_starts", mem_we, 1);
        chk("t2_drain_first_addr", mem_addr, 20'h80000);
        we_cnt = 1;
        last_addr = '0;
        last_dat = '0;
        for (int i = 0; i < 44; i++) begin
            tick();
            if (mem_we) begin
                we_cnt++;
                last_addr = mem_addr;
                last_dat = mem_wdata;
            end
        end
        chk("t2_drain_count", we_cnt, 40);
        chk("t2_last_addr", last_addr, 20'h80027);
        chk("t2_last_data", last_dat, 12'h027);
        chk("t2_level_empty", fifo_level, 0);

        // 3: frame completes, swap at frame start; read in the swap cycle uses the old bank
        do_reset();
        push(19'h0, 12'hA00, 1'b0);
        push(19'h1, 12'hA01, 1'b0);
        push(19'h2, 12'hA02, 1'b1);
        repeat (3) tick();
        chk("t3_bank_before", disp_bank, 0);
        disp_frame_start = 1'b1;
        disp_rd = 1'b1;
        disp_rd_addr = 19'h9;
        tick();
        disp_frame_start = 1'b0;
        chk("t3_swap_rd_addr", mem_addr, 20'h00009);
        chk("t3_disp_bank", disp_bank, 1);
        tick();
        chk("t3_post_swap_rd_addr", mem_addr, 20'h80009);
        disp_rd = 1'b0;
        tick();
        push(19'h5, 12'hABC, 1'b0);
        tick();
        chk("t3_wr_we", mem_we, 1);
        chk("t3_wr_addr_bank0", mem_addr, 20'h00005);
        chk("t3_wr_data", mem_wdata, 12'hABC);
        disp_frame_start = 1'b1;
        tick();
        disp_frame_start = 1'b0;
        chk("t3_no_second_swap", disp_bank, 1);

        // Mid-frame reset drops queued writes and restores the banks
        disp_rd = 1'b1;
        push(19'h6, 12'h006, 1'b0);
        push(19'h7, 12'h007, 1'b0);
        chk("midrst_level_before", fifo_level, 2);
        rstn = 1'b0;
        #1;
        chk("midrst_level", fifo_level, 0);
        chk("midrst_disp_bank", disp_bank, 0);
        do_reset();

        // 4: two frames before any frame start -> one dropped
        push(19'h0, 12'hB00, 1'b0);
        push(19'h1, 12'hB01, 1'b1);
        push(19'h0, 12'hC00, 1'b0);
        push(19'h1, 12'hC01, 1'b1);
        repeat (3) tick();
        chk("t4_dropped", frames_dropped, 1);
        disp_frame_start = 1'b1;
        tick();
        disp_frame_start = 1'b0;
        chk("t4_disp_bank", disp_bank, 1);

        // 5: overflow at depth 64, clear priority, push accepted when full with a pop
        do_reset();
        disp_rd = 1'b1;
        for (int i = 0; i < 65; i++) push(19'(i), 12'(12'h100 + i), 1'b0);
        chk("t5_level_full", fifo_level, 64);
        chk("t5_ovf_set", fifo_overflow, 1);
        ovf_clr = 1'b1;
        tick();
        chk("t5_ovf_cleared", fifo_overflow, 0);
        push(19'h70, 12'h777, 1'b0);
        chk("t5_set_wins", fifo_overflow, 1);
        tick();
        chk("t5_ovf_cleared2", fifo_overflow, 0);
        ovf_clr = 1'b0;
        disp_rd = 1'b0;
        push(19'h7F, 12'h1FF, 1'b0);
        chk("t5_full_push_pop_level", fifo_level, 64);
        chk("t5_full_push_pop_ovf", fifo_overflow, 0);
        chk("t5_first_drain_data", mem_wdata, 12'h100);
        we_cnt = mem_we ? 1 : 0;
        bad_seen = 1'b0;
        last_dat = '0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (mem_we) begin
                we_cnt++;
                last_dat = mem_wdata;
                if (mem_wdata == 12'h140 || mem_wdata == 12'h777) bad_seen = 1'b1;
            end
        end
        chk("t5_drain_count", we_cnt, 65);
        chk("t5_last_data", last_dat, 12'h1FF);
        chk("t5_dropped_never_written", bad_seen, 0);

        // 6: frame start with queued writes -> one idle cycle, then writes to the new wr_bank
        do_reset();
        push(19'h0, 12'hD00, 1'b0);
        push(19'h1, 12'hD01, 1'b1);
        repeat (3) tick();
        disp_rd = 1'b1;
        push(19'h10, 12'hC01, 1'b0);
        push(19'h11, 12'hC02, 1'b0);
        chk("t6_level_queued", fifo_level, 2);
        disp_rd = 1'b0;
        disp_frame_start = 1'b1;
        tick();
        disp_frame_start = 1'b0;
        chk("t6_idle_mem_en", mem_en, 0);
        chk("t6_level_held", fifo_level, 2);
        chk("t6_swapped", disp_bank, 1);
        tick();
        chk("t6_resume_we", mem_we, 1);
        chk("t6_resume_addr", mem_addr, 20'h00010);
        chk("t6_resume_data", mem_wdata, 12'hC01);
        tick();
        chk("t6_second_addr", mem_addr, 20'h00011);
        chk("t6_level_empty", fifo_level, 0);

        // Drop counter saturates at 255 (257 single-pixel frames, 256 drops)
        do_reset();
        for (int i = 0; i < 257; i++) push(19'(i), 12'(i), 1'b1);
        repeat (3) tick();
        chk("sat_dropped", frames_dropped, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
